// File: rtl/enc8b10b_tx_sched.sv
// Transmit link scheduler: picks one 8B/10B symbol per cycle (sync commas, idles, SOF,
// payload, filler, EOF, abort) and drives the encoder's kd/data_in/rd_init from registers.
module enc8b10b_tx_sched #(
  parameter int unsigned SYNC_LEN = 16,
  parameter int unsigned IFG_MIN  = 2,
  parameter int unsigned MAX_LEN  = 256,
  parameter int unsigned LEN_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_en,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        enc_kd,
  output logic [7:0]  enc_data,
  output logic        enc_rd_init,
  output logic        sym_valid,
  output logic        frame_done,
  output logic        trunc_err,
  output logic        abort_pulse,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned SyncW = $clog2(SYNC_LEN) + 1;
  localparam int unsigned GapW  = $clog2(IFG_MIN + 1) + 1;

  localparam logic [2:0] StDisabled = 3'd0;
  localparam logic [2:0] StSync     = 3'd1;
  localparam logic [2:0] StIdle     = 3'd2;
  localparam logic [2:0] StSof      = 3'd3;
  localparam logic [2:0] StData     = 3'd4;
  localparam logic [2:0] StEof      = 3'd5;

  localparam logic [7:0] SymComma = 8'hBC;  // K28.5
  localparam logic [7:0] SymSof   = 8'hFB;  // K27.7
  localparam logic [7:0] SymEof   = 8'hFD;  // K29.7
  localparam logic [7:0] SymFill  = 8'h1C;  // K28.0
  localparam logic [7:0] SymAbort = 8'hFE;  // K30.7

  logic [2:0]       r_state, w_state_d;
  logic [SyncW-1:0] r_sync_cnt, w_sync_cnt_d;
  logic [GapW-1:0]  r_gap, w_gap_d, w_gap_inc;
  logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt_d, w_byte_inc;
  logic             r_trunc, w_trunc_d;
  logic             r_kd, w_kd_d;
  logic [7:0]       r_data, w_data_d;
  logic             r_rd_init, w_rd_init_d;
  logic             r_sym_valid, w_sym_valid_d;
  logic             r_done, w_done_d;
  logic             r_trunc_err, w_trunc_err_d;
  logic             r_abort, w_abort_d;
  logic [15:0]      r_underrun, w_underrun_d;
  logic             w_len_hit;

  assign s_ready    = link_en && (r_state == StData);
  assign w_gap_inc  = (r_gap == GapW'(IFG_MIN)) ? r_gap : r_gap + 1'b1;
  assign w_byte_inc = r_byte_cnt + 1'b1;
  assign w_len_hit  = (w_byte_inc == LEN_W'(MAX_LEN));

  always_comb begin
    w_state_d     = r_state;
    w_sync_cnt_d  = r_sync_cnt;
    w_gap_d       = r_gap;
    w_byte_cnt_d  = r_byte_cnt;
    w_trunc_d     = r_trunc;
    w_kd_d        = 1'b1;
    w_data_d      = SymComma;
    w_rd_init_d   = 1'b0;
    w_sym_valid_d = 1'b1;
    w_done_d      = 1'b0;
    w_trunc_err_d = 1'b0;
    w_abort_d     = 1'b0;
    w_underrun_d  = r_underrun;

    if (!link_en) begin
      w_state_d    = StDisabled;
      w_sync_cnt_d = '0;
      w_trunc_d    = 1'b0;
      // An open frame is closed with an abort; everywhere else the link just goes quiet.
      if (r_state == StData || r_state == StSof) begin
        w_data_d  = SymAbort;
        w_abort_d = 1'b1;
        w_gap_d   = '0;
      end else begin
        w_rd_init_d   = 1'b1;
        w_sym_valid_d = 1'b0;
      end
    end else begin
      case (r_state)
        StDisabled: begin
          w_rd_init_d   = 1'b1;
          w_sym_valid_d = 1'b0;
          w_sync_cnt_d  = '0;
          w_state_d     = StSync;
        end
        StSync: begin
          w_rd_init_d = (r_sync_cnt == '0);
          if (r_sync_cnt == SyncW'(SYNC_LEN - 1)) begin
            w_sync_cnt_d = '0;
            w_state_d    = StIdle;
          end else begin
            w_sync_cnt_d = r_sync_cnt + 1'b1;
          end
        end
        StIdle: begin
          // The idle emitted now counts toward the gap, so exactly IFG_MIN commas precede SOF.
          if (s_valid && (w_gap_inc >= GapW'(IFG_MIN))) begin
            w_state_d = StSof;
          end else begin
            w_gap_d = w_gap_inc;
          end
        end
        StSof: begin
          w_data_d     = SymSof;
          w_byte_cnt_d = '0;
          w_state_d    = StData;
        end
        StData: begin
          if (s_valid) begin
            w_kd_d       = 1'b0;
            w_data_d     = s_data;
            w_byte_cnt_d = w_byte_inc;
            if (s_last || w_len_hit) begin
              w_trunc_d = !s_last;
              w_state_d = StEof;
            end
          end else begin
            w_data_d     = SymFill;
            w_underrun_d = (r_underrun == 16'hFFFF) ? r_underrun : r_underrun + 16'd1;
          end
        end
        StEof: begin
          w_data_d      = SymEof;
          w_done_d      = 1'b1;
          w_trunc_err_d = r_trunc;
          w_trunc_d     = 1'b0;
          w_gap_d       = '0;
          w_state_d     = StIdle;
        end
        default: begin
          w_rd_init_d   = 1'b1;
          w_sym_valid_d = 1'b0;
          w_state_d     = StDisabled;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StSync;
      r_sync_cnt  <= '0;
      r_gap       <= '0;
      r_byte_cnt  <= '0;
      r_trunc     <= 1'b0;
      r_kd        <= 1'b1;
      r_data      <= SymComma;
      r_rd_init   <= 1'b1;
      r_sym_valid <= 1'b0;
      r_done      <= 1'b0;
      r_trunc_err <= 1'b0;
      r_abort     <= 1'b0;
      r_underrun  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sync_cnt  <= w_sync_cnt_d;
      r_gap       <= w_gap_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_trunc     <= w_trunc_d;
      r_kd        <= w_kd_d;
      r_data      <= w_data_d;
      r_rd_init   <= w_rd_init_d;
      r_sym_valid <= w_sym_valid_d;
      r_done      <= w_done_d;
      r_trunc_err <= w_trunc_err_d;
      r_abort     <= w_abort_d;
      r_underrun  <= w_underrun_d;
    end
  end

  assign enc_kd       = r_kd;
  assign enc_data     = r_data;
  assign enc_rd_init  = r_rd_init;
  assign sym_valid    = r_sym_valid;
  assign frame_done   = r_done;
  assign trunc_err    = r_trunc_err;
  assign abort_pulse  = r_abort;
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_enc8b10b_tx_sched.sv
// Bench for enc8b10b_tx_sched: directed framing scenarios pinned by literal symbol
// sequences, then randomized traffic checked every cycle against an owed-symbol model.
module tb_enc8b10b_tx_sched;

  localparam int SyncLen = 16;
  localparam int IfgMin  = 2;
  localparam int MaxLen  = 8;
  localparam int LenW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_en = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        enc_kd;
  logic [7:0]  enc_data;
  logic        enc_rd_init;
  logic        sym_valid;
  logic        frame_done;
  logic        trunc_err;
  logic        abort_pulse;
  logic [15:0] underrun_cnt;

  enc8b10b_tx_sched #(
    .SYNC_LEN(SyncLen),
    .IFG_MIN (IfgMin),
    .MAX_LEN (MaxLen),
    .LEN_W   (LenW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_en     (link_en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .enc_kd      (enc_kd),
    .enc_data    (enc_data),
    .enc_rd_init (enc_rd_init),
    .sym_valid   (sym_valid),
    .frame_done  (frame_done),
    .trunc_err   (trunc_err),
    .abort_pulse (abort_pulse),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         stall;
  } beat_t;

  typedef struct packed {
    logic       ready;
    logic       abort;
    logic       trunc;
    logic       done;
    logic       valid;
    logic       rd;
    logic       kd;
    logic [7:0] data;
  } obs_t;

  beat_t      src_q[$];
  obs_t       log_q[$];
  logic [8:0] exp_seq[$];
  logic       link_drv = 1'b1;
  int         n_vec = 0;
  int         n_err = 0;

  // Model: the link owes symbols (sync commas, SOF, EOF) and emits them in priority order.
  bit         m_up, m_sync_first, m_in_data, m_sof_owed, m_eof_owed, m_trunc_owed;
  int         m_sync_left, m_idles, m_nbytes, m_under;
  logic       e_kd, e_rd, e_valid, e_done, e_trunc, e_abort;
  logic [7:0] e_data;
  int         e_under;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_up = 1; m_sync_left = SyncLen; m_sync_first = 1;
    m_in_data = 0; m_sof_owed = 0; m_eof_owed = 0; m_trunc_owed = 0;
    m_idles = 0; m_nbytes = 0; m_under = 0;
    e_kd = 1; e_data = 8'hBC; e_rd = 1; e_valid = 0;
    e_done = 0; e_trunc = 0; e_abort = 0; e_under = 0;
  endtask

  task automatic model_step(input bit le, input bit sv, input logic [7:0] sd, input bit sl,
                            output bit ready, output bit took);
    logic       n_kd = 1, n_rd = 0, n_valid = 1, n_done = 0, n_trunc = 0, n_abort = 0;
    logic [7:0] n_data = 8'hBC;
    ready = 0;
    took  = 0;
    if (!m_up) begin
      n_rd = 1; n_valid = 0;
      if (le) begin m_up = 1; m_sync_left = SyncLen; m_sync_first = 1; end
    end else if (!le) begin
      if (m_sof_owed || m_in_data) begin
        n_data = 8'hFE; n_abort = 1; m_idles = 0;
      end else begin
        n_rd = 1; n_valid = 0;
      end
      m_up = 0; m_sof_owed = 0; m_in_data = 0; m_eof_owed = 0; m_trunc_owed = 0;
      m_sync_left = 0;
    end else if (m_sync_left > 0) begin
      n_rd = m_sync_first; m_sync_first = 0; m_sync_left--;
    end else if (m_eof_owed) begin
      n_data = 8'hFD; n_done = 1; n_trunc = m_trunc_owed;
      m_eof_owed = 0; m_trunc_owed = 0; m_idles = 0;
    end else if (m_sof_owed) begin
      n_data = 8'hFB; m_sof_owed = 0; m_in_data = 1; m_nbytes = 0;
    end else if (m_in_data) begin
      ready = 1;
      if (sv) begin
        took = 1; n_kd = 0; n_data = sd; m_nbytes++;
        if (sl || m_nbytes == MaxLen) begin
          m_in_data = 0; m_eof_owed = 1; m_trunc_owed = !sl;
        end
      end else begin
        n_data = 8'h1C;
        if (m_under < 65535) m_under++;
      end
    end else begin
      if (sv && m_idles + 1 >= IfgMin) m_sof_owed = 1;
      else m_idles++;
    end
    e_kd = n_kd; e_data = n_data; e_rd = n_rd; e_valid = n_valid;
    e_done = n_done; e_trunc = n_trunc; e_abort = n_abort; e_under = m_under;
  endtask

  task automatic check_regs();
    chk("enc_kd", 32'(enc_kd), 32'(e_kd));
    chk("enc_data", 32'(enc_data), 32'(e_data));
    chk("enc_rd_init", 32'(enc_rd_init), 32'(e_rd));
    chk("sym_valid", 32'(sym_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("trunc_err", 32'(trunc_err), 32'(e_trunc));
    chk("abort_pulse", 32'(abort_pulse), 32'(e_abort));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(e_under));
  endtask

  task automatic drive();
    beat_t b;
    link_en = link_drv;
    s_last  = 1'b0;
    if (src_q.size() == 0) begin
      s_valid = 1'b0; s_data = 8'($urandom);
    end else if (src_q[0].stall > 0) begin
      b = src_q[0]; b.stall--; src_q[0] = b;
      s_valid = 1'b0; s_data = 8'($urandom);
    end else begin
      s_valid = 1'b1; s_data = src_q[0].data; s_last = src_q[0].last;
    end
  endtask

  // One clock: drive, check registered outputs and s_ready against the model, advance.
  task automatic step();
    bit   rdy, took;
    obs_t o;
    drive();
    #1;
    check_regs();
    model_step(link_en, s_valid, s_data, s_last, rdy, took);
    chk("s_ready", 32'(s_ready), 32'(rdy));
    o.ready = s_ready; o.abort = abort_pulse; o.trunc = trunc_err; o.done = frame_done;
    o.valid = sym_valid; o.rd = enc_rd_init; o.kd = enc_kd; o.data = enc_data;
    log_q.push_back(o);
    if (took) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  task automatic push_beat(input logic [7:0] d, input logic last, input int stall);
    beat_t b;
    b.data = d; b.last = last; b.stall = stall;
    src_q.push_back(b);
  endtask

  function automatic obs_t obs_at(input int i);
    obs_t o = '0;
    if (i >= 0 && i < log_q.size()) o = log_q[i];
    return o;
  endfunction

  function automatic int find_sym(input int from, input logic [7:0] d);
    if (from < 0) return -1;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].valid && log_q[i].kd && log_q[i].data == d) return i;
    return -1;
  endfunction

  function automatic int count_ready();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].ready) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].done) n++;
    return n;
  endfunction

  task automatic chk_seq(input string name, input int at);
    int   bad = 0;
    obs_t o;
    if (at < 0) bad = 1000;
    else
      for (int i = 0; i < exp_seq.size(); i++) begin
        o = obs_at(at + i);
        if (!o.valid || {o.kd, o.data} != exp_seq[i]) bad++;
      end
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic reset_midrun();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("async_rst_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int   a, b, li, off_cnt;
    int   bad;
    obs_t o;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_kd", 32'(enc_kd), 32'd1);
    chk("rst_data", 32'(enc_data), 32'hBC);
    chk("rst_rd_init", 32'(enc_rd_init), 32'd1);
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_pulses", 32'({frame_done, trunc_err, abort_pulse}), 32'd0);
    rst_n = 1'b1;

    // Link sync after reset, no traffic.
    log_q.delete();
    repeat (20) step();
    bad = 0;
    for (int i = 1; i < 20; i++) begin
      o = obs_at(i);
      if (!o.valid || !o.kd || o.data != 8'hBC) bad++;
      if (o.rd != (i == 1)) bad++;
    end
    chk("sync_commas", 32'(bad), 32'd0);
    chk("sync_first_rd", 32'(obs_at(1).rd), 32'd1);
    chk("sync_ready_cnt", 32'(count_ready()), 32'd0);

    // 4-byte frame.
    for (int i = 1; i <= 4; i++) push_beat(8'(i), i == 4, 0);
    log_q.delete();
    repeat (12) step();
    a = find_sym(0, 8'hFB);
    exp_seq = {9'h1FB, 9'h001, 9'h002, 9'h003, 9'h004, 9'h1FD};
    chk_seq("frame4_seq", a);
    chk("frame4_done_at_eof", 32'(obs_at(a + 5).done), 32'd1);
    chk("frame4_done_cnt", 32'(count_done()), 32'd1);
    chk("frame4_ready_cnt", 32'(count_ready()), 32'd4);

    // Back-to-back frames honour the inter-frame gap.
    push_beat(8'h11, 0, 0); push_beat(8'h12, 1, 0);
    push_beat(8'h21, 0, 0); push_beat(8'h22, 1, 0);
    log_q.delete();
    repeat (20) step();
    a = find_sym(0, 8'hFB);
    exp_seq = {9'h1FB, 9'h011, 9'h012, 9'h1FD, 9'h1BC, 9'h1BC, 9'h1FB, 9'h021, 9'h022, 9'h1FD};
    chk_seq("b2b_seq", a);

    // Source stalls for 3 cycles mid-frame.
    push_beat(8'h31, 0, 0); push_beat(8'h32, 0, 0); push_beat(8'h33, 0, 3);
    push_beat(8'h34, 0, 0); push_beat(8'h35, 1, 0);
    log_q.delete();
    repeat (20) step();
    exp_seq = {9'h1FB, 9'h031, 9'h032, 9'h11C, 9'h11C, 9'h11C, 9'h033, 9'h034, 9'h035,
               9'h1FD};
    chk_seq("underrun_seq", find_sym(0, 8'hFB));
    chk("underrun_total", 32'(underrun_cnt), 32'd3);

    // Ten bytes against MaxLen=8: truncated frame, then the remainder as a new frame.
    for (int i = 0; i < 10; i++) push_beat(8'hA0 + 8'(i), i == 9, 0);
    log_q.delete();
    repeat (30) step();
    a = find_sym(0, 8'hFB);
    exp_seq.delete();
    exp_seq.push_back(9'h1FB);
    for (int i = 0; i < 8; i++) exp_seq.push_back({1'b0, 8'hA0 + 8'(i)});
    exp_seq.push_back(9'h1FD);
    chk_seq("trunc_seq", a);
    chk("trunc_flag", 32'({obs_at(a + 9).trunc, obs_at(a + 9).done}), 32'd3);
    b = find_sym(a + 10, 8'hFB);
    chk("trunc_gap_ok", 32'(b - (a + 9) - 1 >= 2), 32'd1);
    exp_seq = {9'h1FB, 9'h0A8, 9'h0A9, 9'h1FD};
    chk_seq("trunc_rest_seq", b);
    chk("trunc_rest_flag", 32'({obs_at(b + 3).trunc, obs_at(b + 3).done}), 32'd1);

    // Link drop after two payload bytes, then re-enable.
    for (int i = 0; i < 6; i++) push_beat(8'hC0 + 8'(i), i == 5, 0);
    log_q.delete();
    for (int n = 0; n < 60 && src_q.size() > 4; n++) step();
    chk("abort_setup_bound", 32'(src_q.size()), 32'd4);
    link_drv = 1'b0;
    repeat (5) step();
    link_drv = 1'b1;
    repeat (40) step();
    a = find_sym(0, 8'hFE);
    exp_seq = {9'h0C0, 9'h0C1, 9'h1FE};
    chk_seq("abort_seq", a - 2);
    chk("abort_pulse_at_fe", 32'(obs_at(a).abort), 32'd1);
    o = obs_at(a + 1);
    chk("abort_then_disabled", 32'({o.valid, o.rd, o.kd, o.data}), 32'h3BC);
    li = -1;
    foreach (log_q[i]) if (!log_q[i].valid) li = i;
    chk("resync_first_rd", 32'({obs_at(li + 1).rd, obs_at(li + 2).rd}), 32'h2);
    b = find_sym(li + 1, 8'hFB);
    chk("resync_len_ok", 32'(b - li - 1 >= SyncLen), 32'd1);
    exp_seq = {9'h1FB, 9'h0C2, 9'h0C3, 9'h0C4, 9'h0C5, 9'h1FD};
    chk_seq("resume_seq", b);

    // Randomized traffic, link drops and one async reset inside a frame.
    off_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (src_q.size() < 3) begin
        a = $urandom_range(1, 12);
        for (int i = 0; i < a; i++)
          push_beat(8'($urandom), i == a - 1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      if (link_drv && $urandom_range(0, 199) == 0) begin
        link_drv = 1'b0; off_cnt = $urandom_range(1, 20);
      end else if (!link_drv) begin
        off_cnt--;
        if (off_cnt <= 0) link_drv = 1'b1;
      end
      if (cyc == 1500) begin
        link_drv = 1'b1;
        for (int n = 0; n < 300 && !m_in_data; n++) step();
        chk("midframe_reached", 32'(m_in_data), 32'd1);
        reset_midrun();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
